axis_pattern_gen: RTL and testbench
===================================

# axis_pattern_gen

Parametrised AXI4-Stream traffic source, the successor to the fixed counter source used in the FIFO simulation benches. It adds runtime-configurable frame length, an enforced inter-frame gap, a bounded frame count and selectable data patterns (counter, LFSR, walking-one). It drives the slave side of any FIFO or DUT under test and fully honours backpressure. It also flags start-of-frame on TUSER so checkers can align without counting beats.

## Interface
- DATA_W, 32, TDATA width; multiple of 8, ≥16
- USER_W, 1, TUSER width; bit 0 = SOF, upper bits 0
- KEEP_W, DATA_W/8, TKEEP width

Ports:
- aclk  in  1  clock; all logic on rising edge
- areset  in  1  asynchronous, active-high reset
- enable  in  1  level; start/continue generation
- cfg_mode  in  2  0 counter, 1 LFSR, 2 walking-one, 3 = counter
- cfg_frame_len  in  16  beats per frame; 0 treated as 1
- cfg_gap_len  in  16  idle cycles (TVALID=0) between frames
- cfg_num_frames  in  16  frames per run; 0 = unbounded
- m_axis_tvalid / tready / tdata / tkeep / tlast / tuser  out/in/out/out/out/out  1/1/DATA_W/KEEP_W/1/USER_W  AXI4-Stream master
- busy  out  1  state ≠ IDLE and ≠ DONE
- done  out  1  run of cfg_num_frames completed
- frame_count  out  32  frames completed since reset; wraps at 2^32

## Operation
- Config is latched on the IDLE→SEND transition; changes mid-run are ignored.
- States: IDLE, SEND, GAP, DONE.
- IDLE: tvalid=0. enable=1 → latch config, reset beat_idx=0, frame_id=0, LFSR=32'hFFFFFFFF; present beat 0 (tvalid=1), go to SEND.
- SEND, handshake (tvalid&tready) on a non-last beat: present next beat.
- SEND, handshake on the last beat (beat_idx==len−1), evaluated in priority order:
  1. frame_count++, frame_id++.
  2. If cfg_num_frames≠0 and the run count reaches cfg_num_frames → DONE.
  3. Else if stop is pending → IDLE.
  4. Else if gap==0 → present beat 0 of the next frame in the same cycle (back-to-back, tvalid stays 1).
  5. Else → GAP.
- Stop: enable=0 while in SEND sets stop-pending. The current frame always completes; frames are never truncated.
- GAP: tvalid=0 for exactly cfg_gap_len cycles, then present beat 0 and go to SEND. enable=0 in GAP → IDLE immediately.
- DONE: done=1, tvalid=0. enable=0 → IDLE (done clears).
- Beat payload:
  - tkeep = all ones.
  - tlast = (beat_idx==len−1).
  - tuser[0] = (beat_idx==0).
  - Mode 0: tdata[15:0]=beat_idx, tdata[DATA_W-1:16]=frame_id truncated.
  - Mode 1: tdata = 32-bit Galois LFSR (x^32+x^22+x^2+x+1) replicated/truncated to DATA_W. LFSR advances one step per handshake only.
  - Mode 2: tdata = 1 << (beat_idx mod DATA_W).
- A single-beat frame (len 1) has tlast=1 and tuser[0]=1 on the same beat.

## Timing
- Reset values: tvalid 0, tdata 0, tkeep all ones, tlast 0, tuser 0, busy 0, done 0, frame_count 0, state IDLE. These apply asynchronously on areset assertion; reset mid-frame discards the frame.
- Outputs are registered. The first tvalid appears 1 cycle after enable is sampled high in IDLE.
- Once tvalid=1, tdata/tlast/tuser/tkeep are stable until the handshake. tvalid never drops without a handshake, including on enable deassertion.
- With tready held at 1, throughput is 1 beat/cycle within a frame. Frame period = len + gap cycles.
- done asserts the cycle after the final handshake. frame_count updates the cycle after each last-beat handshake.

## Test plan
- Counter, len=8, gap=0, num=2, tready=1: 16 contiguous beats. Frame 1 tdata = 0x0000_0000…0x0000_0007; frame 2 tdata = 0x0001_0000…0x0001_0007. tlast on beats 7 and 15, tuser on beats 0 and 8. done=1, frame_count=2.
- Gap check, len=4, gap=16, num=3: exactly 16 tvalid=0 cycles between each tlast handshake and the next SOF. No gap after the third frame.
- Backpressure: random 50% tready, LFSR mode, len=5. Each beat is held stable while tready=0. The first 3 accepted words are 0xFFFFFFFF, then the 1st and 2nd LFSR successors; no beat is lost or duplicated.
- Stop mid-frame: len=8, num=0. Drop enable after beat 3 is accepted → beats 4–7 are still sent, then IDLE with busy=0. Re-enable restarts at frame_id 0, beat 0.
- Edge cases: len=0 gives 1-beat frames with tlast=tuser=1. Walking-one with DATA_W=16 and len=20: beat 16 tdata = 0x0001.
- Reset asserted mid-frame with tready=0: tvalid=0 immediately. After release, no output until enable is sampled high.

Source files
------------

// File: rtl/axis_pattern_gen_if.sv
// axis_if: AXI4-Stream bundle shared by the pattern generator and its consumers.
interface axis_if #(
    parameter int DATA_W = 32,
    parameter int USER_W = 1,
    parameter int KEEP_W = DATA_W / 8
);
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tlast;
    logic [USER_W-1:0] tuser;
    modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
    modport slave (input tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/axis_pattern_gen.sv
// axis_pattern_gen: configurable AXI4-Stream source with counter, LFSR and walking-one payloads,
// frame length, inter-frame gap and bounded frame count.
module axis_pattern_gen #(
    parameter int DATA_W = 32,
    parameter int USER_W = 1,
    parameter int KEEP_W = DATA_W / 8
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        enable,
    input  logic [1:0]  cfg_mode,
    input  logic [15:0] cfg_frame_len,
    input  logic [15:0] cfg_gap_len,
    input  logic [15:0] cfg_num_frames,
    axis_if.master      m_axis,
    output logic        busy,
    output logic        done,
    output logic [31:0] frame_count
);
    localparam int REP = (DATA_W + 31) / 32;
    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;
    state_t      state;
    logic [1:0]  mode_q;
    logic [15:0] len_q, gap_q, num_q, run_cnt, gap_cnt, beat_idx, cfg_len;
    logic [31:0] frame_id, lfsr, lfsr_nx;
    logic        stop_pend, hs, last;

    function automatic logic [DATA_W-1:0] beat_data(input logic [1:0] m, input logic [15:0] b,
                                                   input logic [31:0] f, input logic [31:0] l);
        return m == 2'd1 ? DATA_W'({REP{l}}) :
               m == 2'd2 ? DATA_W'(1) << (32'(b) % DATA_W) : DATA_W'({f, b});
    endfunction

    assign cfg_len = cfg_frame_len == 16'd0 ? 16'd1 : cfg_frame_len;
    assign lfsr_nx = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);
    assign hs = m_axis.tvalid && m_axis.tready;
    assign last = beat_idx == len_q - 16'd1;
    assign busy = state == SEND || state == GAP;
    assign m_axis.tkeep = {KEEP_W{1'b1}};

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state         <= IDLE;
            mode_q        <= '0;
            len_q         <= 16'd1;
            gap_q         <= '0;
            num_q         <= '0;
            run_cnt       <= '0;
            gap_cnt       <= '0;
            beat_idx      <= '0;
            frame_id      <= '0;
            lfsr          <= '1;
            stop_pend     <= 1'b0;
            m_axis.tvalid <= 1'b0;
            m_axis.tdata  <= '0;
            m_axis.tlast  <= 1'b0;
            m_axis.tuser  <= '0;
            done          <= 1'b0;
            frame_count   <= '0;
        end else begin
            case (state)
                IDLE: if (enable) begin
                    mode_q        <= cfg_mode;
                    len_q         <= cfg_len;
                    gap_q         <= cfg_gap_len;
                    num_q         <= cfg_num_frames;
                    beat_idx      <= '0;
                    frame_id      <= '0;
                    run_cnt       <= '0;
                    lfsr          <= '1;
                    stop_pend     <= 1'b0;
                    m_axis.tvalid <= 1'b1;
                    m_axis.tdata  <= beat_data(cfg_mode, 16'd0, 32'd0, 32'hFFFF_FFFF);
                    m_axis.tlast  <= cfg_len == 16'd1;
                    m_axis.tuser  <= USER_W'(1);
                    state         <= SEND;
                end
                SEND: begin
                    if (!enable) stop_pend <= 1'b1;
                    if (hs) begin
                        lfsr <= lfsr_nx;
                        if (!last) begin
                            beat_idx     <= beat_idx + 16'd1;
                            m_axis.tdata <= beat_data(mode_q, beat_idx + 16'd1, frame_id, lfsr_nx);
                            m_axis.tlast <= beat_idx + 16'd2 == len_q;
                            m_axis.tuser <= '0;
                        end else begin
                            beat_idx    <= '0;
                            frame_id    <= frame_id + 32'd1;
                            run_cnt     <= run_cnt + 16'd1;
                            frame_count <= frame_count + 32'd1;
                            // a frame that completes the run wins over a pending stop
                            if (num_q != 16'd0 && run_cnt + 16'd1 == num_q) begin
                                state         <= DONE;
                                m_axis.tvalid <= 1'b0;
                                done          <= 1'b1;
                            end else if (stop_pend || !enable) begin
                                state         <= IDLE;
                                m_axis.tvalid <= 1'b0;
                            end else if (gap_q == 16'd0) begin
                                m_axis.tdata <= beat_data(mode_q, 16'd0, frame_id + 32'd1, lfsr_nx);
                                m_axis.tlast <= len_q == 16'd1;
                                m_axis.tuser <= USER_W'(1);
                            end else begin
                                state         <= GAP;
                                m_axis.tvalid <= 1'b0;
                                gap_cnt       <= gap_q;
                            end
                        end
                    end
                end
                GAP: if (!enable) begin
                    state <= IDLE;
                end else if (gap_cnt == 16'd1) begin
                    state         <= SEND;
                    m_axis.tvalid <= 1'b1;
                    m_axis.tdata  <= beat_data(mode_q, 16'd0, frame_id, lfsr);
                    m_axis.tlast  <= len_q == 16'd1;
                    m_axis.tuser  <= USER_W'(1);
                end else begin
                    gap_cnt <= gap_cnt - 16'd1;
                end
                DONE: if (!enable) begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axis_pattern_gen.sv
// tb_axis_pattern_gen: directed runs with random backpressure against a beat-level reference model;
// a 16-bit instance shadows the 32-bit one to cover narrow-bus payloads.
module tb_axis_pattern_gen;
    logic        aclk = 1'b0, areset = 1'b1, enable = 1'b0;
    logic [1:0]  cfg_mode = '0;
    logic [15:0] cfg_frame_len = '0, cfg_gap_len = '0, cfg_num_frames = '0;
    logic        busy, done, busy16, done16;
    logic [31:0] frame_count, frame_count16;
    int          total = 0, passed = 0, fails = 0, fc_exp = 0;

    axis_if #(.DATA_W(32)) s32 ();
    axis_if #(.DATA_W(16)) s16 ();
    assign s16.tready = s32.tready;

    always #5 aclk = ~aclk;

    axis_pattern_gen #(.DATA_W(32)) dut (
        .aclk(aclk), .areset(areset), .enable(enable), .cfg_mode(cfg_mode),
        .cfg_frame_len(cfg_frame_len), .cfg_gap_len(cfg_gap_len), .cfg_num_frames(cfg_num_frames),
        .m_axis(s32), .busy(busy), .done(done), .frame_count(frame_count));

    axis_pattern_gen #(.DATA_W(16)) dut16 (
        .aclk(aclk), .areset(areset), .enable(enable), .cfg_mode(cfg_mode),
        .cfg_frame_len(cfg_frame_len), .cfg_gap_len(cfg_gap_len), .cfg_num_frames(cfg_num_frames),
        .m_axis(s16), .busy(busy16), .done(done16), .frame_count(frame_count16));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // x^32+x^22+x^2+x+1 stepped in right-shifting Galois form: each tap x^e toggles bit e-1
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        logic [31:0] mask = '0;
        int taps[4] = '{32, 22, 2, 1};
        foreach (taps[i]) mask[taps[i]-1] = 1'b1;
        return s[0] ? (s >> 1) ^ mask : s >> 1;
    endfunction

    function automatic logic [31:0] exp_data(input int w, input int mode, input int b, input int f,
                                             input logic [31:0] lf);
        logic [31:0] d;
        d = mode == 1 ? lf : mode == 2 ? 32'd1 << (b % w) : 32'(f) * 32'h1_0000 + 32'(b);
        return w == 32 ? d : d & 32'hFFFF;
    endfunction

    task automatic run(input int mode, input int len, input int gap, input int num, input int rdy,
                       input int stop_at);
        int b = 0, f = 0, gl = 0, fd = 0, post = 0, el;
        bit fin = 0, by_num = 0, stopping = 0, mv, hs;
        logic [31:0] lf = 32'hFFFF_FFFF;
        el = len == 0 ? 1 : len;
        @(negedge aclk);
        cfg_mode = 2'(mode);
        cfg_frame_len = 16'(len);
        cfg_gap_len = 16'(gap);
        cfg_num_frames = 16'(num);
        s32.tready = 1'b0;
        enable = 1'b1;
        for (int c = 0; c < 3000 && post < 3; c++) begin
            @(negedge aclk);
            mv = !fin && gl == 0;
            chk("tvalid", 32'(s32.tvalid), 32'(mv));
            chk("tvalid16", 32'(s16.tvalid), 32'(mv));
            chk("busy", 32'(busy), 32'(!fin));
            chk("done", 32'(done), 32'(by_num));
            chk("frame_count", frame_count, fc_exp);
            if (mv) begin
                chk("tdata", s32.tdata, exp_data(32, mode, b, f, lf));
                chk("tdata16", 32'(s16.tdata), exp_data(16, mode, b, f, lf));
                chk("tlast", 32'(s32.tlast), 32'(b == el - 1));
                chk("tuser", 32'(s32.tuser), 32'(b == 0));
                chk("tkeep", 32'(s32.tkeep), 32'hF);
            end
            // config changes after the run has started must be ignored
            if (c == 0) begin
                cfg_mode = 2'($urandom);
                cfg_frame_len = 16'($urandom_range(1, 30));
                cfg_gap_len = 16'($urandom_range(0, 9));
                cfg_num_frames = 16'($urandom_range(0, 5));
            end
            s32.tready = $urandom_range(99) < rdy;
            hs = mv && s32.tready;
            if (fin) post++;
            else if (gl > 0) gl--;
            else if (hs) begin
                lf = lfsr_step(lf);
                if (b == stop_at && f == 0) begin
                    enable = 1'b0;
                    stopping = 1;
                end
                if (b < el - 1) b++;
                else begin
                    b = 0;
                    f++;
                    fd++;
                    fc_exp++;
                    if (num != 0 && fd == num) begin
                        fin = 1;
                        by_num = 1;
                    end else if (stopping) fin = 1;
                    else gl = gap;
                end
            end
        end
        chk("run_end", 32'(fin && post >= 3), 32'd1);
        chk("frame_count16", frame_count16, fc_exp);
        chk("done16", 32'(done16), 32'(by_num));
        chk("busy16", 32'(busy16), 32'd0);
        enable = 1'b0;
        repeat (2) @(negedge aclk);
        chk("done_clear", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        s32.tready = 1'b0;
        #12;
        chk("rst_tvalid", 32'(s32.tvalid), 32'd0);
        chk("rst_tdata", s32.tdata, 32'd0);
        chk("rst_tkeep", 32'(s32.tkeep), 32'hF);
        chk("rst_tlast", 32'(s32.tlast), 32'd0);
        chk("rst_tuser", 32'(s32.tuser), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_frame_count", frame_count, 32'd0);
        @(negedge aclk);
        areset = 1'b0;
        run(0, 8, 0, 2, 100, -1);
        run(0, 4, 16, 3, 100, -1);
        run(1, 5, int'($urandom_range(0, 3)), 4, 50, -1);
        run(0, 8, 0, 0, 60, 3);
        run(0, 3, 1, 2, 70, -1);
        run(2, 0, 0, 3, 100, -1);
        run(2, 20, 0, 1, 80, -1);
        for (int i = 0; i < 3; i++)
            run(int'($urandom_range(0, 3)), int'($urandom_range(0, 12)), int'($urandom_range(0, 5)),
                int'($urandom_range(1, 3)), int'($urandom_range(30, 100)), -1);
        @(negedge aclk);
        cfg_mode = 2'd0;
        cfg_frame_len = 16'd6;
        cfg_gap_len = 16'd0;
        cfg_num_frames = 16'd0;
        s32.tready = 1'b0;
        enable = 1'b1;
        repeat (2) @(negedge aclk);
        chk("pre_reset_tvalid", 32'(s32.tvalid), 32'd1);
        #2 areset = 1'b1;
        #1;
        chk("async_rst_tvalid", 32'(s32.tvalid), 32'd0);
        chk("async_rst_frame_count", frame_count, 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        enable = 1'b0;
        fc_exp = 0;
        @(negedge aclk);
        areset = 1'b0;
        repeat (3) begin
            @(negedge aclk);
            chk("post_rst_idle", 32'(s32.tvalid), 32'd0);
        end
        run(0, 4, 2, 2, 100, -1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
